// File: rtl/grande_risco5_amo_unit.sv
// rtl/grande_risco5_amo_unit.sv - RV32A atomic responder: AMO read-modify-write, LR/SC with a single reservation
module grande_risco5_amo_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [4:0]            funct5_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    input  logic                  snoop_wr_i,
    input  logic [ADDR_WIDTH-1:0] snoop_addr_i
);

    localparam logic [6:0] ATOMIC_OPCODE = 7'b0101111;
    localparam logic [2:0] FUNCT3_W      = 3'b010;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    localparam int WA = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WA-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [4:0]            funct5_q, funct5_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q, err_d;
    logic                  resv_valid_q, resv_valid_d;
    logic [WA-1:0]         resv_addr_q, resv_addr_d;

    logic                  f5_legal;
    logic                  req_err;
    logic                  sc_hit;
    logic [DATA_WIDTH-1:0] amo_new;
    logic                  snoop_lsb_unused;

    // Byte offset of a snooped store is irrelevant: reservations are word granular.
    assign snoop_lsb_unused = ^snoop_addr_i[1:0];

    // Decode legality of the incoming request and whether an SC would hit the reservation.
    always_comb begin
        f5_legal = 1'b0;
        case (funct5_i)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: f5_legal = 1'b1;
            default:                          f5_legal = 1'b0;
        endcase
        req_err = (opcode_i != ATOMIC_OPCODE) || (funct3_i != FUNCT3_W) ||
                  !f5_legal || (addr_i[1:0] != 2'b00);
        sc_hit  = resv_valid_q && (resv_addr_q == addr_i[ADDR_WIDTH-1:2]);
    end

    // New memory value for an AMO, from the old word on the bus and the latched rs2.
    always_comb begin
        amo_new = rs2_q;
        case (funct5_q)
            F5_SWAP: amo_new = rs2_q;
            F5_ADD:  amo_new = mem_rdata_i + rs2_q;
            F5_XOR:  amo_new = mem_rdata_i ^ rs2_q;
            F5_AND:  amo_new = mem_rdata_i & rs2_q;
            F5_OR:   amo_new = mem_rdata_i | rs2_q;
            F5_MIN:  amo_new = ($signed(mem_rdata_i) < $signed(rs2_q)) ? mem_rdata_i : rs2_q;
            F5_MAX:  amo_new = ($signed(mem_rdata_i) > $signed(rs2_q)) ? mem_rdata_i : rs2_q;
            F5_MINU: amo_new = (mem_rdata_i < rs2_q) ? mem_rdata_i : rs2_q;
            F5_MAXU: amo_new = (mem_rdata_i > rs2_q) ? mem_rdata_i : rs2_q;
            default: amo_new = rs2_q;
        endcase
    end

    // Sequencer next state; the snoop clear is applied last so it beats a same-cycle LR ack.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rs2_d        = rs2_q;
        funct5_d     = funct5_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        err_d        = err_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d   = addr_i[ADDR_WIDTH-1:2];
                    rs2_d    = rs2_i;
                    funct5_d = funct5_i;
                    err_d    = 1'b0;
                    if (req_err) begin
                        err_d     = 1'b1;
                        rd_data_d = '0;
                        state_d   = ST_DONE;
                    end else if (funct5_i == F5_SC) begin
                        resv_valid_d = 1'b0;
                        if (sc_hit) begin
                            wdata_d   = rs2_i;
                            rd_data_d = '0;
                            state_d   = ST_WRITE;
                        end else begin
                            rd_data_d = DATA_WIDTH'(1);
                            state_d   = ST_DONE;
                        end
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (mem_ack_i) begin
                    rd_data_d = mem_rdata_i;
                    if (funct5_q == F5_LR) begin
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q;
                        state_d      = ST_DONE;
                    end else begin
                        wdata_d = amo_new;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack_i) begin
                    if (resv_valid_q && (resv_addr_q == addr_q)) begin
                        resv_valid_d = 1'b0;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (snoop_wr_i && (snoop_addr_i[ADDR_WIDTH-1:2] == resv_addr_d)) begin
            resv_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rs2_q        <= '0;
            funct5_q     <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            funct5_q     <= funct5_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q && (state_q == ST_DONE);
    assign rd_data_o   = rd_data_q;
    assign mem_rd_o    = (state_q == ST_READ);
    assign mem_wr_o    = (state_q == ST_WRITE);
    assign mem_addr_o  = {addr_q, 2'b00};
    assign mem_wdata_o = wdata_q;

endmodule
